// File: rtl/spell_ram_arbiter.sv
// Two-requester Wishbone arbiter for the shared spell RAM: one transfer per grant, alternating on ties.
// Optional ack-wait timeout enabled by defining SPELL_ARB_TIMEOUT_EN.
module spell_ram_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [7:0]  m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [7:0]  m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [7:0]  rambus_wb_addr_o,
  output logic [31:0] rambus_wb_dat_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i,

  output logic [1:0]  grant_o,
  output logic        timeout_flag_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state;
  state_t next_state;
  logic   last_grant;
  logic   next_last_grant;
  logic   m0_req;
  logic   m1_req;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("spell_ram_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  // State encoding doubles as the one-hot grant, so grant_o is loaded from next_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_o    <= 2'b00;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
      grant_o    <= next_state;
    end
  end

`ifdef SPELL_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_count;
  logic       timeout_flag;

  // wait_count holds the number of earlier unacked grant cycles, so the limit is hit on cycle TIMEOUT_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count   <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_count <= 8'd0;
      end else if (!rambus_wb_ack_i) begin
        wait_count <= wait_count + 8'd1;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign timeout_hit    = (state != IDLE) && !rambus_wb_ack_i && (wait_count == TIMEOUT_LAST);
  assign timeout_flag_o = timeout_flag;
`else
  assign timeout_hit    = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif

  always_comb begin
    next_state       = state;
    next_last_grant  = last_grant;
    rambus_wb_cyc_o  = 1'b0;
    rambus_wb_stb_o  = 1'b0;
    rambus_wb_we_o   = 1'b0;
    rambus_wb_sel_o  = 4'd0;
    rambus_wb_addr_o = 8'd0;
    rambus_wb_dat_o  = 32'd0;
    m0_ack_o         = 1'b0;
    m0_err_o         = 1'b0;
    m0_dat_o         = 32'd0;
    m1_ack_o         = 1'b0;
    m1_err_o         = 1'b0;
    m1_dat_o         = 32'd0;

    case (state)
      IDLE: begin
        // On a tie, last_grant == 1 means m1 went last, so m0 takes this one.
        if (m0_req && m1_req) begin
          next_state = last_grant ? GRANT0 : GRANT1;
        end else if (m0_req) begin
          next_state = GRANT0;
        end else if (m1_req) begin
          next_state = GRANT1;
        end
      end

      GRANT0: begin
        rambus_wb_cyc_o  = m0_cyc_i;
        rambus_wb_stb_o  = m0_stb_i;
        rambus_wb_we_o   = m0_we_i;
        rambus_wb_sel_o  = m0_sel_i;
        rambus_wb_addr_o = m0_addr_i;
        rambus_wb_dat_o  = m0_dat_i;
        m0_ack_o         = rambus_wb_ack_i;
        m0_dat_o         = rambus_wb_dat_i;
        m0_err_o         = timeout_hit;
        if (!m0_cyc_i || rambus_wb_ack_i || timeout_hit) begin
          next_state      = IDLE;
          next_last_grant = 1'b0;
        end
      end

      GRANT1: begin
        rambus_wb_cyc_o  = m1_cyc_i;
        rambus_wb_stb_o  = m1_stb_i;
        rambus_wb_we_o   = m1_we_i;
        rambus_wb_sel_o  = m1_sel_i;
        rambus_wb_addr_o = m1_addr_i;
        rambus_wb_dat_o  = m1_dat_i;
        m1_ack_o         = rambus_wb_ack_i;
        m1_dat_o         = rambus_wb_dat_i;
        m1_err_o         = timeout_hit;
        if (!m1_cyc_i || rambus_wb_ack_i || timeout_hit) begin
          next_state      = IDLE;
          next_last_grant = 1'b1;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spell_ram_arbiter.sv
// Directed self-checking bench for spell_ram_arbiter; timeout cases run when SPELL_ARB_TIMEOUT_EN is defined.
module tb_spell_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [7:0]  m0_addr;
  logic [31:0] m0_wdat;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [7:0]  m1_addr;
  logic [31:0] m1_wdat;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        ram_cyc, ram_stb, ram_we;
  logic [3:0]  ram_sel;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdat;
  logic        ram_ack;
  logic [31:0] ram_rdat;
  logic [1:0]  grant;
  logic        timeout_flag;

  int check_count = 0;
  int fail_count  = 0;

  spell_ram_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .m0_cyc_i         (m0_cyc),
    .m0_stb_i         (m0_stb),
    .m0_we_i          (m0_we),
    .m0_sel_i         (m0_sel),
    .m0_addr_i        (m0_addr),
    .m0_dat_i         (m0_wdat),
    .m0_ack_o         (m0_ack),
    .m0_err_o         (m0_err),
    .m0_dat_o         (m0_rdat),
    .m1_cyc_i         (m1_cyc),
    .m1_stb_i         (m1_stb),
    .m1_we_i          (m1_we),
    .m1_sel_i         (m1_sel),
    .m1_addr_i        (m1_addr),
    .m1_dat_i         (m1_wdat),
    .m1_ack_o         (m1_ack),
    .m1_err_o         (m1_err),
    .m1_dat_o         (m1_rdat),
    .rambus_wb_cyc_o  (ram_cyc),
    .rambus_wb_stb_o  (ram_stb),
    .rambus_wb_we_o   (ram_we),
    .rambus_wb_sel_o  (ram_sel),
    .rambus_wb_addr_o (ram_addr),
    .rambus_wb_dat_o  (ram_wdat),
    .rambus_wb_ack_i  (ram_ack),
    .rambus_wb_dat_i  (ram_rdat),
    .grant_o          (grant),
    .timeout_flag_o   (timeout_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int master, input logic cyc, input logic stb, input logic we,
                               input logic [3:0] sel, input logic [7:0] addr, input logic [31:0] dat);
    if (master == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdat = dat;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow a further settle delay.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    ram_ack  = 1'b0;
    ram_rdat = 32'd0;
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    tick();
    tick();
    settle();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_cyc", 32'(ram_cyc), 32'h0);
    checkOutput("rst_m0_ack", 32'(m0_ack), 32'h0);
    checkOutput("rst_m1_ack", 32'(m1_ack), 32'h0);
    checkOutput("rst_flag", 32'(timeout_flag), 32'h0);
    reset = 1'b0;
    tick();

    $display("[TB] single m0 write");
    applyStimulus(0, 1, 1, 1, 4'hF, 8'h12, 32'hDEADBEEF);
    settle();
    checkOutput("t1_idle_grant", 32'(grant), 32'h0);
    checkOutput("t1_idle_cyc", 32'(ram_cyc), 32'h0);
    tick();
    settle();
    checkOutput("t1_grant", 32'(grant), 32'h1);
    checkOutput("t1_cyc", 32'(ram_cyc), 32'h1);
    checkOutput("t1_we", 32'(ram_we), 32'h1);
    checkOutput("t1_sel", 32'(ram_sel), 32'hF);
    checkOutput("t1_addr", 32'(ram_addr), 32'h12);
    checkOutput("t1_wdat", ram_wdat, 32'hDEADBEEF);
    checkOutput("t1_ack_early", 32'(m0_ack), 32'h0);
    tick();
    checkOutput("t1_grant_hold", 32'(grant), 32'h1);
    ram_ack = 1'b1;
    settle();
    checkOutput("t1_m0_ack", 32'(m0_ack), 32'h1);
    checkOutput("t1_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    ram_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    settle();
    checkOutput("t1_after_grant", 32'(grant), 32'h0);
    checkOutput("t1_after_ack", 32'(m0_ack), 32'h0);
    checkOutput("t1_after_cyc", 32'(ram_cyc), 32'h0);

    $display("[TB] stray ack in idle");
    ram_ack = 1'b1;
    settle();
    checkOutput("idle_ack_m0", 32'(m0_ack), 32'h0);
    checkOutput("idle_ack_m1", 32'(m1_ack), 32'h0);
    tick();
    checkOutput("idle_ack_grant", 32'(grant), 32'h0);
    ram_ack = 1'b0;

    $display("[TB] round robin after reset");
    reset = 1'b1;
    applyStimulus(0, 1, 1, 0, 4'hF, 8'h01, 32'd0);
    applyStimulus(1, 1, 1, 0, 4'hF, 8'h02, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_grant;
      logic [7:0] exp_addr;
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (i % 2 == 0) ? 8'h01 : 8'h02;
      tick();
      settle();
      checkOutput($sformatf("rr%0d_grant", i), 32'(grant), 32'(exp_grant));
      checkOutput($sformatf("rr%0d_addr", i), 32'(ram_addr), 32'(exp_addr));
      ram_ack = 1'b1;
      settle();
      checkOutput($sformatf("rr%0d_m0_ack", i), 32'(m0_ack), 32'(exp_grant[0]));
      checkOutput($sformatf("rr%0d_m1_ack", i), 32'(m1_ack), 32'(exp_grant[1]));
      tick();
      ram_ack = 1'b0;
      settle();
      checkOutput($sformatf("rr%0d_idle", i), 32'(grant), 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    tick();

    $display("[TB] m1 read");
    applyStimulus(1, 1, 1, 0, 4'hF, 8'h40, 32'd0);
    tick();
    settle();
    checkOutput("t3_grant", 32'(grant), 32'h2);
    checkOutput("t3_addr", 32'(ram_addr), 32'h40);
    checkOutput("t3_we", 32'(ram_we), 32'h0);
    ram_ack  = 1'b1;
    ram_rdat = 32'hA5A5A5A5;
    settle();
    checkOutput("t3_m1_dat", m1_rdat, 32'hA5A5A5A5);
    checkOutput("t3_m1_ack", 32'(m1_ack), 32'h1);
    checkOutput("t3_m0_ack", 32'(m0_ack), 32'h0);
    checkOutput("t3_m0_dat", m0_rdat, 32'h0);
    tick();
    ram_ack  = 1'b0;
    ram_rdat = 32'd0;
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    settle();
    checkOutput("t3_idle", 32'(grant), 32'h0);

    $display("[TB] reset during grant");
    applyStimulus(1, 1, 1, 1, 4'h3, 8'h55, 32'h12345678);
    tick();
    settle();
    checkOutput("t4_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    tick();
    settle();
    checkOutput("t4_rst_grant", 32'(grant), 32'h0);
    checkOutput("t4_rst_cyc", 32'(ram_cyc), 32'h0);
    ram_ack = 1'b1;
    settle();
    checkOutput("t4_late_ack_m1", 32'(m1_ack), 32'h0);
    checkOutput("t4_late_ack_m0", 32'(m0_ack), 32'h0);
    reset   = 1'b0;
    ram_ack = 1'b0;
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    tick();

    $display("[TB] m0 abandons cycle with m1 pending");
    applyStimulus(0, 1, 1, 0, 4'hF, 8'h08, 32'd0);
    tick();
    settle();
    checkOutput("t5_grant0", 32'(grant), 32'h1);
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    applyStimulus(1, 1, 1, 0, 4'hF, 8'h09, 32'd0);
    settle();
    checkOutput("t5_drop_cyc", 32'(ram_cyc), 32'h0);
    checkOutput("t5_drop_ack", 32'(m0_ack), 32'h0);
    checkOutput("t5_drop_err", 32'(m0_err), 32'h0);
    tick();
    settle();
    checkOutput("t5_idle", 32'(grant), 32'h0);
    tick();
    settle();
    checkOutput("t5_grant1", 32'(grant), 32'h2);
    checkOutput("t5_addr", 32'(ram_addr), 32'h09);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    settle();
    checkOutput("t5_flag", 32'(timeout_flag), 32'h0);
    tick();

`ifdef SPELL_ARB_TIMEOUT_EN
    $display("[TB] ack on limit cycle beats timeout");
    applyStimulus(0, 1, 1, 0, 4'hF, 8'h20, 32'd0);
    tick();
    tick();
    tick();
    tick();
    settle();
    checkOutput("to_pri_grant", 32'(grant), 32'h1);
    ram_ack = 1'b1;
    settle();
    checkOutput("to_pri_ack", 32'(m0_ack), 32'h1);
    checkOutput("to_pri_err", 32'(m0_err), 32'h0);
    tick();
    ram_ack = 1'b0;
    settle();
    checkOutput("to_pri_flag", 32'(timeout_flag), 32'h0);
    checkOutput("to_pri_idle", 32'(grant), 32'h0);

    $display("[TB] timeout on m0");
    tick();
    settle();
    checkOutput("to_c1_grant", 32'(grant), 32'h1);
    checkOutput("to_c1_err", 32'(m0_err), 32'h0);
    tick();
    tick();
    settle();
    checkOutput("to_c3_err", 32'(m0_err), 32'h0);
    tick();
    settle();
    checkOutput("to_c4_err", 32'(m0_err), 32'h1);
    checkOutput("to_c4_ack", 32'(m0_ack), 32'h0);
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    applyStimulus(1, 1, 1, 0, 4'hF, 8'h30, 32'd0);
    tick();
    settle();
    checkOutput("to_after_idle", 32'(grant), 32'h0);
    checkOutput("to_after_err", 32'(m0_err), 32'h0);
    checkOutput("to_after_flag", 32'(timeout_flag), 32'h1);
    tick();
    settle();
    checkOutput("to_m1_grant", 32'(grant), 32'h2);
    checkOutput("to_m1_err", 32'(m1_err), 32'h0);
    ram_ack = 1'b1;
    settle();
    checkOutput("to_m1_ack", 32'(m1_ack), 32'h1);
    tick();
    ram_ack = 1'b0;
    applyStimulus(1, 0, 0, 0, 4'h0, 8'h00, 32'd0);
    settle();
    checkOutput("to_flag_sticky", 32'(timeout_flag), 32'h1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
